// File: rtl/tt_vector_checker_if.sv
// Bus between the vector checker and the combinational block under test.
// FAIL_MASK_EN adds the per-vector fail_mask result.
interface tt_vector_checker_if;
    logic        start;
    logic [3:0]  vec_out;
    logic        dut_f;
    logic        dut_g;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_idx;
    logic        first_fail_valid;
`ifdef FAIL_MASK_EN
    logic [15:0] fail_mask;
`endif

    modport master (
        input  start,
        input  dut_f,
        input  dut_g,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail_idx,
`ifdef FAIL_MASK_EN
        output fail_mask,
`endif
        output first_fail_valid
    );

    modport slave (
        output start,
        output dut_f,
        output dut_g,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail_idx,
`ifdef FAIL_MASK_EN
        input  fail_mask,
`endif
        input  first_fail_valid
    );
endinterface

// File: rtl/tt_vector_checker.sv
// Exhaustive 4-input self-test: walks vectors 0..15, samples f/g at end of hold.
// Optional FAIL_MASK_EN records which vectors failed in fail_mask.
module tt_vector_checker #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'hA5C3,
    parameter logic [15:0] EXP_G       = 16'h3C96
) (
    input logic                  clk,
    input logic                  rst,
    tt_vector_checker_if.master  bus
);
    localparam int unsigned CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] hold_q;
    logic [3:0]    vec_q;
    logic [4:0]    err_q;
    logic [3:0]    ffi_q;
    logic          ffv_q;
`ifdef FAIL_MASK_EN
    logic [15:0]   mask_q;
`endif

    logic sample;
    logic launch;
    logic mismatch;

    assign sample   = (state_q == RUN) && (hold_q == LAST);
    assign launch   = bus.start && (state_q != RUN);
    assign mismatch = (bus.dut_f != EXP_F[vec_q]) ||
                      (bus.dut_g != EXP_G[vec_q]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: start launches from IDLE/DONE, last sample of vector 15 ends.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (sample && vec_q == 4'd15) state_d = DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Hold counter, vector walk and result accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            vec_q  <= '0;
            err_q  <= '0;
            ffi_q  <= '0;
            ffv_q  <= 1'b0;
`ifdef FAIL_MASK_EN
            mask_q <= '0;
`endif
        end else if (launch) begin
            hold_q <= '0;
            vec_q  <= '0;
            err_q  <= '0;
            ffi_q  <= '0;
            ffv_q  <= 1'b0;
`ifdef FAIL_MASK_EN
            mask_q <= '0;
`endif
        end else if (sample) begin
            hold_q <= '0;
            if (vec_q != 4'd15) vec_q <= vec_q + 4'd1;
            if (mismatch) begin
                err_q <= err_q + 5'd1;
`ifdef FAIL_MASK_EN
                mask_q[vec_q] <= 1'b1;
`endif
                if (!ffv_q) begin
                    ffi_q <= vec_q;
                    ffv_q <= 1'b1;
                end
            end
        end else if (state_q == RUN) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign bus.vec_out          = vec_q;
    assign bus.busy             = (state_q == RUN);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = (state_q == DONE) && (err_q == 5'd0);
    assign bus.err_count        = err_q;
    assign bus.first_fail_idx   = ffi_q;
    assign bus.first_fail_valid = ffv_q;
`ifdef FAIL_MASK_EN
    assign bus.fail_mask        = mask_q;
`endif
endmodule

// File: tb/tb_tt_vector_checker.sv
// Bench for tt_vector_checker: emulated DUT modes, table of runs, scoreboard.
// Build with +define+FAIL_MASK_EN to also check fail_mask.
module tb_tt_vector_checker;
    localparam logic [15:0] EXP_F = 16'hA5C3;
    localparam logic [15:0] EXP_G = 16'h3C96;
    localparam int LIMIT = 400;
    localparam int M_GOLD = 0, M_F0 = 1, M_GINV = 2, M_V5 = 3, M_GLITCH = 4;

    typedef struct {
        int          mode;
        int          err;
        int          ffi;
        int          ffv;
        int          pass_e;
        logic [15:0] mask;
    } vec_t;

    logic clk;
    logic rst;
    int   mode;
    int   settle;
    logic [3:0] prev_vec;
    int   errors;
    int   checks;
    vec_t tbl[5];
    vec_t sb[$];

    tt_vector_checker_if bus();

    tt_vector_checker #(
        .HOLD_CYCLES(20),
        .EXP_F(EXP_F),
        .EXP_G(EXP_G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since vec_out last changed, for the glitch mode.
    always @(posedge clk) begin
        prev_vec <= bus.vec_out;
        if (bus.vec_out != prev_vec) settle <= 0;
        else if (settle < 1000) settle <= settle + 1;
    end

    // Emulated combinational block under test.
    always_comb begin
        logic [15:0] ef;
        logic [15:0] eg;
        logic f;
        logic g;
        ef = EXP_F;
        eg = EXP_G;
        f = ef[bus.vec_out];
        g = eg[bus.vec_out];
        case (mode)
            M_F0:   f = 1'b0;
            M_GINV: g = ~g;
            M_V5: if (bus.vec_out == 4'd5) begin
                f = ~f;
                g = ~g;
            end
            M_GLITCH: if (settle < 10) begin
                f = ~f;
                g = ~g;
            end
            default: ;
        endcase
        bus.dut_f = f;
        bus.dut_g = g;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " vec_out"}, int'(bus.vec_out), 0);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk({tag, " done"}, int'(bus.done), 0);
        chk({tag, " pass"}, int'(bus.pass), 0);
        chk({tag, " err_count"}, int'(bus.err_count), 0);
        chk({tag, " ffi"}, int'(bus.first_fail_idx), 0);
        chk({tag, " ffv"}, int'(bus.first_fail_valid), 0);
`ifdef FAIL_MASK_EN
        chk({tag, " fail_mask"}, int'(bus.fail_mask), 0);
`endif
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < LIMIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, lat, 320);
        chk({tag, " done"}, int'(bus.done), 1);
        chk({tag, " busy"}, int'(bus.busy), 0);
        chk({tag, " vec_out"}, int'(bus.vec_out), 15);
        chk({tag, " err_count"}, int'(bus.err_count), e.err);
        chk({tag, " ffi"}, int'(bus.first_fail_idx), e.ffi);
        chk({tag, " ffv"}, int'(bus.first_fail_valid), e.ffv);
        chk({tag, " pass"}, int'(bus.pass), e.pass_e);
`ifdef FAIL_MASK_EN
        chk({tag, " fail_mask"}, int'(bus.fail_mask), int'(e.mask));
        chk({tag, " popcount"}, $countones(bus.fail_mask), int'(bus.err_count));
`endif
    endtask

    initial begin
        int lat;
        int to;
        errors = 0;
        checks = 0;
        mode = M_GOLD;
        bus.start = 1'b0;
        rst = 1'b1;

        tbl[0] = '{M_GOLD,   0, 0, 0, 1, 16'h0000};
        tbl[1] = '{M_F0,     8, 0, 1, 0, 16'hA5C3};
        tbl[2] = '{M_GINV,  16, 0, 1, 0, 16'hFFFF};
        tbl[3] = '{M_V5,     1, 5, 1, 0, 16'h0020};
        tbl[4] = '{M_GLITCH, 0, 0, 0, 1, 16'h0000};

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("idle");

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            sb.push_back(tbl[i]);
            start_run();
            wait_done(lat);
            check_result($sformatf("tbl%0d", i), lat);
        end

        // Reset in the middle of vector 7, then a clean golden run.
        mode = M_F0;
        start_run();
        to = 0;
        while (bus.vec_out != 4'd7 && to < LIMIT) begin
            @(posedge clk);
            #1;
            to++;
        end
        chk("reach vec7", int'(bus.vec_out), 7);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        mode = M_GOLD;
        sb.push_back(tbl[0]);
        start_run();
        wait_done(lat);
        check_result("after_rst", lat);

        // Repeated start pulses during RUN must not restart the run.
        sb.push_back(tbl[1]);
        mode = M_F0;
        start_run();
        fork
            wait_done(lat);
            begin
                repeat (8) begin
                    repeat (37) @(negedge clk);
                    bus.start = 1'b1;
                    @(negedge clk);
                    bus.start = 1'b0;
                end
            end
        join
        check_result("start_in_run", lat);

        // Start in DONE restarts with results cleared.
        mode = M_V5;
        sb.push_back(tbl[3]);
        start_run();
        chk("restart done", int'(bus.done), 0);
        chk("restart busy", int'(bus.busy), 1);
        chk("restart err", int'(bus.err_count), 0);
        chk("restart ffv", int'(bus.first_fail_valid), 0);
        chk("restart vec", int'(bus.vec_out), 0);
        wait_done(lat);
        check_result("restart", lat);

        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
